c7bicu: RTL

//  Instruction cache unit front end, directly upstream of the IFU fetch stage.

---
 rtl/c7bicu_pkg.sv | 13 +
 rtl/c7bicu_lbuf.sv | 42 ++++
 rtl/c7bicu.sv | 122 ++++++++++++
 3 files changed

// File: rtl/c7bicu_pkg.sv
// Shared definitions for the c7bicu instruction-fetch front end: FSM encodings and line geometry.
package c7bicu_pkg;

  typedef enum logic [1:0] {
    ICU_IDLE = 2'd0,
    ICU_REQ  = 2'd1,
    ICU_WAIT = 2'd2
  } icu_state_e;

  localparam int unsigned ICU_LINE_BYTES = 8;
  localparam int unsigned ICU_OFS_W      = $clog2(ICU_LINE_BYTES);

endpackage

// File: rtl/c7bicu_lbuf.sv
// Single-entry line buffer: tag/data/valid storage, hit compare, invalidate (wins over a same-cycle fill).
module c7bicu_lbuf
  import c7bicu_pkg::*;
#(
  parameter int TW = 29,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [TW-1:0] lookup_tag_i,
  input  logic          lookup_inv_i,
  output logic          hit_o,
  output logic [DW-1:0] data_o,
  input  logic          fill_i,
  input  logic [TW-1:0] fill_tag_i,
  input  logic [DW-1:0] fill_data_i,
  input  logic          inv_i
);

  logic          vld_q;
  logic [TW-1:0] tag_q;
  logic [DW-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
    end else if (inv_i) begin
      vld_q  <= 1'b0;
    end else if (fill_i) begin
      vld_q  <= 1'b1;
      tag_q  <= fill_tag_i;
      data_q <= fill_data_i;
    end
  end

  // An invalidate arriving with the lookup must not be bypassed by a stale hit.
  assign hit_o  = vld_q & (tag_q == lookup_tag_i) & ~lookup_inv_i;
  assign data_o = data_q;

endmodule

// File: rtl/c7bicu.sv
// ICU front end: one outstanding IFU fetch forwarded to the BIU, line returned as a 1-cycle ic2 pulse.
// Optional single-entry line buffer enabled by defining C7B_ICU_LBUF_EN.
module c7bicu
  import c7bicu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ifu_icu_addr_ic1,
  input  logic          ifu_icu_req_ic1,
  output logic          icu_ifu_ack_ic1,
  output logic          icu_ifu_data_valid_ic2,
  output logic [DW-1:0] icu_ifu_data_ic2,
  output logic          icu_ifu_err_ic2,
  input  logic          ifu_icu_inv,
  output logic          icu_biu_req,
  output logic [AW-1:0] icu_biu_addr,
  input  logic          biu_icu_ack,
  input  logic          biu_icu_data_vld,
  input  logic [DW-1:0] biu_icu_data,
  input  logic          biu_icu_err
);

  icu_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          err_q, err_d;
  logic          vld_q, vld_d;
  logic          fill_done;
  logic          lb_hit;
  logic [DW-1:0] lb_data;

  assign icu_ifu_ack_ic1 = ifu_icu_req_ic1 & (state_q == ICU_IDLE);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    err_d       = err_q;
    vld_d       = 1'b0;
    icu_biu_req = 1'b0;
    fill_done   = 1'b0;
    case (state_q)
      ICU_IDLE: begin
        if (icu_ifu_ack_ic1) begin
          if (lb_hit) begin
            vld_d  = 1'b1;
            data_d = lb_data;
            err_d  = 1'b0;
          end else begin
            state_d = ICU_REQ;
            addr_d  = {ifu_icu_addr_ic1[AW-1:ICU_OFS_W], {ICU_OFS_W{1'b0}}};
          end
        end
      end
      ICU_REQ: begin
        icu_biu_req = 1'b1;
        if (biu_icu_ack) state_d = ICU_WAIT;
        fill_done = biu_icu_ack & biu_icu_data_vld;
      end
      ICU_WAIT: fill_done = biu_icu_data_vld;
      default:  state_d = ICU_IDLE;
    endcase
    // Data returned in REQ without an ack, or in IDLE, is never treated as ours.
    if (fill_done) begin
      state_d = ICU_IDLE;
      vld_d   = 1'b1;
      data_d  = biu_icu_data;
      err_d   = biu_icu_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ICU_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
    end
  end

  assign icu_biu_addr           = addr_q;
  assign icu_ifu_data_valid_ic2 = vld_q;
  assign icu_ifu_data_ic2       = data_q;
  assign icu_ifu_err_ic2        = err_q;

`ifdef C7B_ICU_LBUF_EN
  c7bicu_lbuf #(
    .TW(AW - ICU_OFS_W),
    .DW(DW)
  ) u_lbuf (
    .clk          (clk),
    .reset        (reset),
    .lookup_tag_i (ifu_icu_addr_ic1[AW-1:ICU_OFS_W]),
    .lookup_inv_i (ifu_icu_inv),
    .hit_o        (lb_hit),
    .data_o       (lb_data),
    .fill_i       (fill_done & ~biu_icu_err),
    .fill_tag_i   (addr_q[AW-1:ICU_OFS_W]),
    .fill_data_i  (biu_icu_data),
    .inv_i        (ifu_icu_inv | (fill_done & biu_icu_err))
  );
`else
  assign lb_hit  = 1'b0;
  assign lb_data = '0;
  logic unused_inv;
  assign unused_inv = ifu_icu_inv;
`endif

  logic unused_ofs;
  assign unused_ofs = ^ifu_icu_addr_ic1[ICU_OFS_W-1:0];

endmodule
